fifo_uart_tx: RTL and testbench

- Drain stage placed directly downstream of the 8-bit sample FIFO in the FlexEMG data-collection path.
- Pops one byte at a time through the FIFO's read port (1-cycle registered read latency) and serializes it as UART 8N1, LSB first, on tx.
- Drives the host link; provides a busy flag and a completed-frame counter for the host-side status logic.

---
 rtl/fifo_uart_tx.sv | 131 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a registered-read FIFO one byte per frame.
// Counts completed frames and flags activity on busy.
module fifo_uart_tx #(
  parameter int clocks_per_bit = 868,
  parameter int count_width    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [7:0]             fifo_dout,
  output logic                   fifo_rd_en,
  output logic                   tx,
  output logic                   busy,
  output logic [count_width-1:0] frame_count
);

  localparam int BW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(clocks_per_bit - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                 state_r, state_next_s;
  logic [BW-1:0]          baud_r, baud_next_s;
  logic [2:0]             bit_idx_r, bit_idx_next_s;
  logic [7:0]             shift_r, shift_next_s;
  logic                   tx_r, tx_next_s;
  logic [count_width-1:0] count_r, count_next_s;
  logic                   baud_end_s;

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
      count_r   <= '0;
    end else begin
      state_r   <= state_next_s;
      baud_r    <= baud_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
      tx_r      <= tx_next_s;
      count_r   <= count_next_s;
    end
  end

  // Next-state and next-datapath logic; tx is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_next_s   = state_r;
    baud_next_s    = baud_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    tx_next_s      = tx_r;
    count_next_s   = count_r;
    baud_end_s     = (baud_r == BAUD_LAST);
    case (state_r)
      IDLE: begin
        tx_next_s = 1'b1;
        if (en && !fifo_empty) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        state_next_s = LOAD;
      end
      LOAD: begin
        shift_next_s = fifo_dout;
        baud_next_s  = '0;
        tx_next_s    = 1'b0;
        state_next_s = START;
      end
      START: begin
        if (baud_end_s) begin
          baud_next_s    = '0;
          bit_idx_next_s = 3'd0;
          tx_next_s      = shift_r[0];
          state_next_s   = DATA;
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_next_s = '0;
          if (bit_idx_r == 3'd7) begin
            tx_next_s    = 1'b1;
            state_next_s = STOP;
          end else begin
            // shift_r[1] becomes the new LSB, so it is the next bit on the wire
            shift_next_s   = {1'b0, shift_r[7:1]};
            bit_idx_next_s = bit_idx_r + 3'd1;
            tx_next_s      = shift_r[1];
          end
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_next_s  = '0;
          count_next_s = count_r + count_width'(1);
          state_next_s = IDLE;
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
      default: begin
        tx_next_s    = 1'b1;
        state_next_s = IDLE;
      end
    endcase
  end

  assign fifo_rd_en  = (state_r == REQ);
  assign busy        = (state_r != IDLE);
  assign tx          = tx_r;
  assign frame_count = count_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT, a UART monitor
// decodes tx and checks every frame against bytes queued by the stimulus.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst, en, fifo_empty, fifo_rd_en, tx, busy;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] frame_count;

  fifo_uart_tx #(.clocks_per_bit(CPB), .count_width(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_t[$];
  int         frames_done = 0;
  int         rd_pulses   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      tick();
      k++;
    end
    check("frames_done", frames_done, n);
  endtask

  // FIFO model with a 1-cycle registered read; data appears only in the LOAD cycle
  logic [7:0] pend;
  logic       pend_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      rd_pulses = 0;
      pend_v    = 1'b0;
    end else if (fifo_rd_en) begin
      rd_pulses++;
      fifo_dout = 8'hEE;
      if (fifo_q.size() == 0) begin
        check("underflow", 1, 0);
      end else begin
        pend   = fifo_q.pop_front();
        pend_v = 1'b1;
      end
      fifo_empty = (fifo_q.size() == 0);
    end else if (pend_v) begin
      fifo_dout = pend;
      pend_v    = 1'b0;
    end
  end

  // UART monitor: every cycle of a frame is compared with the expected 10-bit pattern
  logic       in_frame = 1'b0;
  logic       prev_tx  = 1'b1;
  logic [9:0] exp_bits;
  logic [7:0] exp_b, got;
  int         pos, shape_err;
  int         model_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_frame    = 1'b0;
      prev_tx     = 1'b1;
      model_cnt   = 0;
      frames_done = 0;
      start_t.delete();
    end else begin
      if (in_frame) begin
        if (pos < 10 * CPB) begin
          if (tx !== exp_bits[pos / CPB] || busy !== 1'b1) shape_err++;
          if (pos % CPB == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 8) got[pos / CPB - 1] = tx;
          pos++;
        end else begin
          check("frame_byte", got, exp_b);
          check("frame_shape", shape_err, 0);
          model_cnt = (model_cnt + 1) % (1 << CW);
          check("frame_count", frame_count, model_cnt);
          check("busy_after_stop", busy, 0);
          in_frame = 1'b0;
          frames_done++;
        end
      end else if (prev_tx && !tx) begin
        start_t.push_back(int'($time / 10));
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          exp_b     = exp_q.pop_front();
          exp_bits  = {1'b1, exp_b, 1'b0};
          got       = 8'd0;
          shape_err = (busy !== 1'b1) ? 1 : 0;
          pos       = 1;
          in_frame  = 1'b1;
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    int viol;
    rst        = 1'b1;
    en         = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = 8'h00;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_frame_count", frame_count, 0);
    rst = 1'b0;
    tick();

    // single 0xA5 frame
    en = 1'b1;
    push(8'hA5);
    wait_frames(1, 100);
    check("t1_pops", rd_pulses, 1);
    check("t1_count", frame_count, 1);

    // back-to-back 0x01, 0xFF, 0x00
    do_reset();
    en = 1'b1;
    push(8'h01); push(8'hFF); push(8'h00);
    wait_frames(3, 300);
    check("t2_starts", start_t.size(), 3);
    if (start_t.size() == 3) begin
      check("t2_period_a", start_t[1] - start_t[0], 43);
      check("t2_period_b", start_t[2] - start_t[1], 43);
    end
    repeat (20) tick();
    check("t2_pops", rd_pulses, 3);
    check("t2_count", frame_count, 3);

    // en low holds off the pop; raising en pops next cycle, tx falls 2 cycles later
    do_reset();
    push(8'h55);
    viol = 0;
    repeat (100) begin
      tick();
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("t3_idle_hold", viol, 0);
    en = 1'b1;
    tick();
    check("t3_rd_en_next", fifo_rd_en, 1);
    tick();
    check("t3_load_rd_en", fifo_rd_en, 0);
    check("t3_load_tx", tx, 1);
    tick();
    check("t3_start_tx", tx, 0);
    wait_frames(1, 100);

    // en dropped during data bit 3 of 0x3C
    do_reset();
    en = 1'b1;
    push(8'h3C); push(8'h99);
    viol = 0;
    while (fifo_rd_en !== 1'b1 && viol < 10) begin
      tick();
      viol++;
    end
    repeat (19) tick();
    en = 1'b0;
    wait_frames(1, 100);
    repeat (60) tick();
    check("t4_pops", rd_pulses, 1);
    check("t4_busy", busy, 0);
    check("t4_tx", tx, 1);

    // asynchronous reset in the middle of the second frame
    do_reset();
    en = 1'b1;
    push(8'h5A); push(8'hC3);
    wait_frames(1, 100);
    viol = 0;
    while (rd_pulses < 2 && viol < 10) begin
      tick();
      viol++;
    end
    repeat (25) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_tx", tx, 1);
    check("t5_async_busy", busy, 0);
    check("t5_async_count", frame_count, 0);
    tick();
    tick();
    rst = 1'b0;
    push(8'h81);
    wait_frames(1, 100);
    check("t5_count", frame_count, 1);

    // 2-bit frame counter wraps
    do_reset();
    en = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    wait_frames(5, 400);
    check("t6_count_wrap", frame_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
